// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and the shift-add-3 helper for the
// 7-segment cell encoder.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_ENC  = 2'd2
    } state_e;

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_digit_rom.sv
// BCD digit to active-high segment code (bit0=a .. bit6=g); 10..15 go dark.
module seg_digit_rom
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Digit lookup.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_cell_encoder.sv
// Binary-to-BCD converter (shift-add-3, WIDTH cycles) feeding four
// 7-segment cell bytes with leading-zero blanking, dp and overflow dashes.
module seg_cell_encoder
    import seg_pkg::*;
#(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       dp_mask_i,
    input  logic             blank_lz_i,
    output logic [7:0]       cell0_o,
    output logic [7:0]       cell1_o,
    output logic [7:0]       cell2_o,
    output logic [7:0]       cell3_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e                            state_q, state_d;
    logic [WIDTH-1:0]                  sh_q, sh_d;
    logic [15:0]                       bcd_q, bcd_d;
    logic [15:0]                       bcd_adj_s;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              ovf_q, ovf_d;
    logic [3:0]                        dp_q, dp_d;
    logic                              blz_q, blz_d;
    logic [NUM_DIGITS-1:0][7:0]        cell_q, cell_d;
    logic                              done_q, done_d;
    logic [NUM_DIGITS-1:0][7:0]        enc_s;
    logic [NUM_DIGITS-1:0]             blank_s;
    logic                              lz_run_s;
    logic [6:0]                        rom_seg_s [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_rom
        seg_digit_rom u_rom (
            .bcd_i (bcd_q[4*g +: 4]),
            .seg_o (rom_seg_s[g])
        );
    end

    // Cell encoding from the finished BCD word; blanking runs from digit 3 downward.
    always_comb begin
        blank_s  = '0;
        lz_run_s = blz_q;
        enc_s    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run_s   = lz_run_s & (bcd_q[4*i +: 4] == 4'd0);
            blank_s[i] = lz_run_s;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf_q) begin
                enc_s[i] = {dp_q[i], SEG_DASH};
            end else if (blank_s[i]) begin
                enc_s[i] = {dp_q[i], SEG_BLANK};
            end else begin
                enc_s[i] = {dp_q[i], rom_seg_s[i]};
            end
        end
    end

    // Next-state logic for the IDLE -> CONV -> ENC sequence.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        dp_d      = dp_q;
        blz_d     = blz_q;
        cell_d    = cell_q;
        done_d    = 1'b0;
        bcd_adj_s = bcd_add3(bcd_q);
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    sh_d    = value_i;
                    bcd_d   = 16'h0000;
                    cnt_d   = CNT_W'(WIDTH);
                    ovf_d   = {{(32-WIDTH){1'b0}}, value_i} > 32'(MAX_VAL);
                    dp_d    = dp_mask_i;
                    blz_d   = blank_lz_i;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                bcd_d = (bcd_adj_s << 1) | {15'd0, sh_q[WIDTH-1]};
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ENC;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_ENC: begin
                cell_d  = enc_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bcd_q   <= 16'h0000;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dp_q    <= 4'h0;
            blz_q   <= 1'b0;
            cell_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dp_q    <= dp_d;
            blz_q   <= blz_d;
            cell_q  <= cell_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign done_o  = done_q;
    assign cell0_o = cell_q[0];
    assign cell1_o = cell_q[1];
    assign cell2_o = cell_q[2];
    assign cell3_o = cell_q[3];

endmodule
